// File: rtl/pc_ctrl.sv
// PC sequencing controller: boots the PC register, fetches through a ready/req handshake,
// and applies trap/jump/branch redirects, holding one pending redirect while a fetch is outstanding.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc_cur,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        trap,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [1:0]  state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BOOT  = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_STALL = 2'd3;

  logic [1:0]  state_r, state_nxt_s;
  logic        pend_vld_r, pend_vld_nxt_s;
  logic        pend_trap_r, pend_trap_nxt_s;
  logic [31:0] pend_tgt_r, pend_tgt_nxt_s;

  logic        redir_s;
  logic [31:0] redir_tgt_s;
  logic        take_new_s;
  logic        merged_vld_s;
  logic        merged_trap_s;
  logic [31:0] merged_tgt_s;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Select this cycle's redirect and fold it into the pending one; a held trap outranks later jmp/br.
  always_comb begin
    redir_s = trap | jmp | br_taken;
    if (trap) begin
      redir_tgt_s = word_align(TRAP_VEC);
    end else if (jmp) begin
      redir_tgt_s = word_align(jmp_target);
    end else if (br_taken) begin
      redir_tgt_s = word_align(br_target);
    end else begin
      redir_tgt_s = 32'h0000_0000;
    end
    take_new_s    = redir_s & ~(pend_vld_r & pend_trap_r & ~trap);
    merged_vld_s  = pend_vld_r | redir_s;
    merged_trap_s = take_new_s ? trap : pend_trap_r;
    merged_tgt_s  = take_new_s ? redir_tgt_s : pend_tgt_r;
  end

  // Next-state and output decode; every output is zero in IDLE, which reset forces asynchronously.
  always_comb begin
    state_nxt_s     = state_r;
    pend_vld_nxt_s  = pend_vld_r;
    pend_trap_nxt_s = pend_trap_r;
    pend_tgt_nxt_s  = pend_tgt_r;
    pc_ena          = 1'b0;
    pc_next         = 32'h0000_0000;
    imem_req        = 1'b0;
    imem_addr       = 32'h0000_0000;
    fetch_valid     = 1'b0;
    fetch_pc        = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_BOOT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BOOT: begin
        pc_ena      = 1'b1;
        pc_next     = RESET_PC;
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_cur;
        if (imem_ready) begin
          pc_ena = 1'b1;
          if (merged_vld_s) begin
            pc_next = merged_tgt_s;
          end else begin
            fetch_valid = 1'b1;
            fetch_pc    = pc_cur;
            pc_next     = pc_cur + 32'd4;
          end
          pend_vld_nxt_s  = 1'b0;
          pend_trap_nxt_s = 1'b0;
          pend_tgt_nxt_s  = 32'h0000_0000;
          state_nxt_s     = stall ? ST_STALL : ST_FETCH;
        end else begin
          pend_vld_nxt_s  = merged_vld_s;
          pend_trap_nxt_s = merged_trap_s;
          pend_tgt_nxt_s  = merged_tgt_s;
          state_nxt_s     = ST_FETCH;
        end
      end
      ST_STALL: begin
        if (redir_s) begin
          pc_ena  = 1'b1;
          pc_next = redir_tgt_s;
        end else begin
          pc_ena  = 1'b0;
        end
        pend_vld_nxt_s  = 1'b0;
        pend_trap_nxt_s = 1'b0;
        pend_tgt_nxt_s  = 32'h0000_0000;
        state_nxt_s     = stall ? ST_STALL : ST_FETCH;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and pending-redirect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      pend_vld_r  <= 1'b0;
      pend_trap_r <= 1'b0;
      pend_tgt_r  <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      pend_vld_r  <= pend_vld_nxt_s;
      pend_trap_r <= pend_trap_nxt_s;
      pend_tgt_r  <= pend_tgt_nxt_s;
    end
  end

  assign state = state_r;

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, the boot address loaded into the PC register after start.
REQ-002 The block SHALL provide parameter TRAP_VEC, default 32'h0000_0008, the trap redirect address.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse; leave IDLE and begin sequencing.
REQ-006 pc_cur  input  32  current PC, the data_out of the PC register.
REQ-007 pc_ena  output  1  write enable to the PC register.
REQ-008 pc_next  output  32  data_in to the PC register; meaningful only when pc_ena=1, otherwise 0.
REQ-009 imem_req / imem_addr  output  1 / 32  instruction fetch request and address.
REQ-010 imem_ready  input  1  fetch completion strobe from instruction memory.
REQ-011 stall  input  1  pipeline backpressure.
REQ-012 br_taken / br_target  input  1 / 32  branch redirect and its target.
REQ-013 jmp / jmp_target  input  1 / 32  jump redirect and its target.
REQ-014 trap  input  1  trap redirect to TRAP_VEC.
REQ-015 fetch_valid / fetch_pc  output  1 / 32  one-cycle pulse marking an accepted fetch, and its address.
REQ-016 state  output  2  IDLE=0, BOOT=1, FETCH=2, STALL=3.

Function
REQ-017 IDLE: all outputs 0; start=1 -> BOOT; all other inputs ignored.
REQ-018 BOOT (one cycle): pc_ena=1, pc_next=RESET_PC; next state FETCH; redirects ignored.
REQ-019 FETCH: imem_req=1 and imem_addr=pc_cur every cycle.
REQ-020 Handshake: once raised, imem_req SHALL stay high with a stable imem_addr until the cycle imem_ready=1.
REQ-021 Completion without redirect (imem_ready=1, no pending redirect, no redirect input that cycle): fetch_valid=1, fetch_pc=pc_cur, pc_ena=1, pc_next=pc_cur+4.
REQ-022 After completion: next state STALL if stall=1 that cycle, else FETCH.
REQ-023 Redirect priority: trap > jmp > br_taken; the selected target has bits [1:0] forced to 0.
REQ-024 Redirect in FETCH coinciding with imem_ready=1: fetch_valid=0 (fetch discarded), pc_ena=1, pc_next=target; then REQ-022 applies.
REQ-025 Redirect in FETCH without imem_ready: target captured in a pending register and imem_req held.
REQ-026 At the completion following REQ-025: fetch discarded, pc_ena=1, pc_next=pending target, pending cleared.
REQ-027 A later redirect SHALL overwrite the pending one, except that a pending trap is never overwritten by jmp or br_taken.
REQ-028 STALL: imem_req=0, pc_ena=0, PC held; stall=0 -> FETCH.
REQ-029 Redirect in STALL: pc_ena=1, pc_next=target in that same cycle, pending cleared; state remains STALL while stall=1.
REQ-030 Sequential increment wraps modulo 2^32: pc_cur=32'hFFFF_FFFC gives pc_next=32'h0000_0000.
REQ-031 Latency: from imem_ready sampled high, the new PC is visible on pc_cur one clock later; imem_req for it follows in that cycle if FETCH.

Reset
REQ-032 rst=0 SHALL asynchronously force state=IDLE, pending cleared, and every output 0, including imem_req and fetch_valid, without waiting for clk.
REQ-033 Reset asserted mid-fetch SHALL drop imem_req immediately; after rst=1 the block stays in IDLE until the next start.

Verification
REQ-034 Boot: rst low then high, start pulse, imem_ready tied 1 -> pc_next sequence 0,4,8,12; fetch_valid high every cycle from the first FETCH.
REQ-035 Wait states: imem_ready low for 3 cycles -> imem_req and imem_addr held stable, no pc_ena until ready, then fetch_valid=1 for one cycle only.
REQ-036 Pending redirect: jmp=1, jmp_target=32'h100 while waiting, then br_taken=1, br_target=32'h200 before ready -> fetch discarded, next PC 32'h200; with trap in place of jmp -> next PC TRAP_VEC.
REQ-037 Simultaneous redirects: trap, jmp and br_taken together with imem_ready -> pc_next=TRAP_VEC and fetch_valid=0; br_target=32'h103 -> pc_next=32'h100.
REQ-038 Stall and wrap: RESET_PC=32'hFFFF_FFF8, stall=1 at the first completion -> STALL entered, PC holds FFFF_FFFC; after release the next PC is 0.
REQ-039 Reset mid-fetch: rst low while imem_req=1 -> imem_req, fetch_valid and state reach 0 before the next clk edge.
